regbank_wr_arbiter: RTL and testbench

- Shares the single register-bank write port (ALUBus data plus one-hot regEnable) between two writeback requesters: A (ALU result) and B (memory load).
- Arbitrates per cycle with round-robin priority and returns a combinational grant.
- Registers the winning write and drives a one-hot 16-bit enable plus 16-bit data into the register bank one cycle later.
- Sits between the execute/memory stages and the register bank.

---
 rtl/regbank_wr_arbiter.sv | 71 +++++++
 tb/tb_regbank_wr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// Two-requester round-robin arbiter for the single register-bank write port.
// Grants are combinational; the winning write is registered into a one-hot enable and data bus.
module regbank_wr_arbiter #(
  parameter int DATA_W     = 16,
  parameter int NREG       = 16,
  parameter bit R0_PROTECT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req_a,
  input  logic [3:0]        addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [3:0]        addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREG-1:0]   regEnable,
  output logic [15:0]       wr_count
);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  src_e              last_gnt;
  logic              commit;
  logic              suppress;
  logic [3:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   win_onehot;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (reset && !stall) begin
      // On conflict the requester that did not win last time goes first.
      if (req_a && (!req_b || last_gnt == SRC_B)) gnt_a = 1'b1;
      else if (req_b)                             gnt_b = 1'b1;
    end
  end

  assign commit     = gnt_a | gnt_b;
  assign win_addr   = gnt_a ? addr_a : addr_b;
  assign win_data   = gnt_a ? data_a : data_b;
  assign suppress   = R0_PROTECT && (win_addr == 4'd0);
  assign win_onehot = NREG'(1) << win_addr;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt  <= SRC_B;
      wr_data   <= '0;
      regEnable <= '0;
      wr_count  <= '0;
    end else if (commit) begin
      last_gnt <= gnt_a ? SRC_A : SRC_B;
      wr_data  <= win_data;
      if (suppress) begin
        regEnable <= '0;
      end else begin
        regEnable <= win_onehot;
        wr_count  <= wr_count + 16'd1;
      end
    end else begin
      regEnable <= '0;
    end
  end

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench with a reference model: expected grants are checked in the request cycle,
// expected commits are queued and compared after the following edge.
module tb_regbank_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 16;

  typedef struct packed {
    logic [NR-1:0] en;
    logic [DW-1:0] data;
    logic [15:0]   count;
  } commit_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          req_a, req_b;
  logic [3:0]    addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] regEnable;
  logic [15:0]   wr_count;

  int total = 0;
  int bad   = 0;

  commit_t       sb_q[$];
  logic          m_last_b;
  logic [DW-1:0] m_data;
  logic [15:0]   m_count;

  regbank_wr_arbiter #(.DATA_W(DW), .NREG(NR), .R0_PROTECT(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .wr_data(wr_data), .regEnable(regEnable), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_b = 1'b1;
    m_data   = '0;
    m_count  = '0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // One request cycle: entered at posedge+1, leaves at the next posedge+1.
  task automatic step(input string tag, input logic st,
                      input logic ra, input logic [3:0] aa, input logic [DW-1:0] da,
                      input logic rb, input logic [3:0] ab, input logic [DW-1:0] db);
    logic    ea, eb;
    commit_t c, got;
    stall = st; req_a = ra; addr_a = aa; data_a = da;
    req_b = rb; addr_b = ab; data_b = db;
    ea = 1'b0; eb = 1'b0;
    if (!st) begin
      if (ra && (!rb || m_last_b)) ea = 1'b1;
      else if (rb)                 eb = 1'b1;
    end
    c.en = '0;
    if (ea || eb) begin
      m_last_b = eb;
      m_data   = ea ? da : db;
      if ((ea ? aa : ab) != 4'd0) begin
        c.en    = NR'(1) << (ea ? aa : ab);
        m_count = m_count + 16'd1;
      end
    end
    c.data  = m_data;
    c.count = m_count;
    sb_q.push_back(c);
    #1;
    check({tag, ".gnt_a"}, 32'(gnt_a), 32'(ea));
    check({tag, ".gnt_b"}, 32'(gnt_b), 32'(eb));
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".regEnable"}, 32'(regEnable), 32'(got.en));
    check({tag, ".wr_data"},   32'(wr_data),   32'(got.data));
    check({tag, ".wr_count"},  32'(wr_count),  32'(got.count));
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
  endtask

  initial begin
    stall = 1'b0; req_a = 1'b1; req_b = 1'b1;
    addr_a = 4'd1; addr_b = 4'd2; data_a = 16'h1111; data_b = 16'h2222;
    reset = 1'b0;
    model_reset();
    #2;
    check("rst.gnt_a", 32'(gnt_a), 32'd0);
    check("rst.gnt_b", 32'(gnt_b), 32'd0);
    check("rst.regEnable", 32'(regEnable), 32'd0);
    check("rst.wr_data", 32'(wr_data), 32'd0);
    check("rst.wr_count", 32'(wr_count), 32'd0);
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Single write from A, then an idle cycle to see the pulse end.
    step("single", 1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, '0);
    idle("single_after");

    // Conflict straight after reset: A first, then B.
    do_reset();
    step("conf1", 1'b0, 1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd7, 16'hBBBB);
    step("conf2", 1'b0, 1'b0, 4'd3, 16'hAAAA, 1'b1, 4'd7, 16'hBBBB);

    // Both held continuously: strict alternation.
    for (int i = 0; i < 6; i++)
      step($sformatf("alt%0d", i), 1'b0, 1'b1, 4'(i + 1), 16'(16'hA000 + i),
           1'b1, 4'(i + 8), 16'(16'hB000 + i));

    // Stall holds off B; last_gnt must survive the stall.
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd6, 16'h6666);
    step("unstall_b", 1'b0, 1'b0, 4'd0, '0, 1'b1, 4'd6, 16'h6666);
    step("post_stall", 1'b0, 1'b1, 4'd2, 16'h2020, 1'b1, 4'd4, 16'h4040);

    // Same address from A then B: later write wins.
    step("same_a", 1'b0, 1'b1, 4'd4, 16'h0011, 1'b0, 4'd0, '0);
    step("same_b", 1'b0, 1'b0, 4'd0, '0, 1'b1, 4'd4, 16'h0022);

    // Protected r0: granted, data loads, no enable, no count.
    step("r0", 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, '0);
    step("r1", 1'b0, 1'b1, 4'd1, 16'h0101, 1'b0, 4'd0, '0);
    idle("r1_after");

    // Async reset between the grant and its commit edge.
    req_a = 1'b1; addr_a = 4'd9; data_a = 16'h9999;
    req_b = 1'b0; stall = 1'b0;
    #1;
    check("r9.gnt_a", 32'(gnt_a), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst.gnt_a", 32'(gnt_a), 32'd0);
    check("arst.regEnable", 32'(regEnable), 32'd0);
    check("arst.wr_count", 32'(wr_count), 32'd0);
    model_reset();
    req_a = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle("arst_idle0");
    idle("arst_idle1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
